// File: rtl/move_seq_pkg.sv
// Shared types, widths and default tuning for the straight-line move sequencer.
package move_seq_pkg;

  localparam int unsigned FRWRD_W = 10;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SQRS_W  = 3;

  localparam logic [FRWRD_W-1:0] FRWRD_INC_DEF = 10'h004;
  localparam logic [FRWRD_W-1:0] FRWRD_MAX_DEF = 10'h300;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    CRUISE  = 2'd2,
    RAMP_DN = 2'd3
  } move_state_t;

  // Saturating ramp-up step; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [FRWRD_W-1:0] ramp_up_step(
    input logic [FRWRD_W-1:0] cur,
    input logic [FRWRD_W-1:0] inc,
    input logic [FRWRD_W-1:0] max_v
  );
    logic [FRWRD_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum >= {1'b0, max_v}) ? max_v : sum[FRWRD_W-1:0];
  endfunction

  // Ramp-down step of twice the increment, clamped at zero.
  function automatic logic [FRWRD_W-1:0] ramp_dn_step(
    input logic [FRWRD_W-1:0] cur,
    input logic [FRWRD_W-1:0] inc
  );
    logic [FRWRD_W:0] dec;
    logic [FRWRD_W:0] diff;
    dec  = {inc, 1'b0};
    diff = {1'b0, cur} - dec;
    return ({1'b0, cur} < dec) ? '0 : diff[FRWRD_W-1:0];
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Command, sensor and PID-side signals of the move sequencer.
interface move_sequencer_if;
  import move_seq_pkg::*;

  logic                cmd_vld;
  logic [SQRS_W-1:0]   cmd_sqrs;
  logic                cmd_rdy;
  logic                hdg_vld;
  logic                cntrIR;
  logic                moving;
  logic [FRWRD_W-1:0]  frwrd;
  logic                err_vld;
  logic                done;

  modport master (
    output cmd_vld, cmd_sqrs, hdg_vld, cntrIR,
    input  cmd_rdy, moving, frwrd, err_vld, done
  );

  modport slave (
    input  cmd_vld, cmd_sqrs, hdg_vld, cntrIR,
    output cmd_rdy, moving, frwrd, err_vld, done
  );

endinterface

// File: rtl/rise_det.sv
// Rising-edge detector with a configurable history reset value.
module rise_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise_c
);

  logic hist_q;
  logic hist_d;

  // History simply follows the input.
  always_comb begin
    hist_d = sig;
  end

  // History flop; reset value chosen by the instantiator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= RST_VAL;
    else        hist_q <= hist_d;
  end

  assign rise_c = sig & ~hist_q;

endmodule

// File: rtl/move_sequencer.sv
// Sequences one straight-line move: ramp up, cruise, count line crossings, ramp down.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter logic [FRWRD_W-1:0] FRWRD_INC = FRWRD_INC_DEF,
  parameter logic [FRWRD_W-1:0] FRWRD_MAX = FRWRD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  move_sequencer_if.slave  bus
);

  move_state_t         state_q,   state_d;
  logic [FRWRD_W-1:0]  frwrd_q,   frwrd_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [CNT_W-1:0]    target_q,  target_d;
  logic                moving_q,  moving_d;
  logic                err_vld_q, err_vld_d;
  logic                done_q,    done_d;

  logic                ir_rise_c;
  logic                counting_c;
  logic                hit_c;

  // A line already under the sensor at reset must not count as a crossing.
  rise_det #(.RST_VAL(1'b1)) u_ir_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig    (bus.cntrIR),
    .rise_c (ir_rise_c)
  );

  // Next-state, ramp arithmetic, crossing counter and output strobes.
  always_comb begin
    state_d    = state_q;
    frwrd_d    = frwrd_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    done_d     = 1'b0;
    counting_c = (state_q == RAMP_UP) || (state_q == CRUISE);
    hit_c      = 1'b0;

    if (counting_c) begin
      cnt_d = cnt_q + CNT_W'(ir_rise_c);
      hit_c = (cnt_d == target_q);
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_vld) begin
          target_d = {bus.cmd_sqrs, 1'b0};
          cnt_d    = '0;
          if (bus.cmd_sqrs != '0) state_d = RAMP_UP;
          else                    done_d  = 1'b1;
        end
      end
      RAMP_UP: begin
        // Target hit wins over the cruise transition and freezes the speed.
        if (hit_c) begin
          state_d = RAMP_DN;
        end else if (bus.hdg_vld) begin
          frwrd_d = ramp_up_step(frwrd_q, FRWRD_INC, FRWRD_MAX);
          if (frwrd_d == FRWRD_MAX) state_d = CRUISE;
        end
      end
      CRUISE: begin
        if (hit_c) state_d = RAMP_DN;
      end
      RAMP_DN: begin
        if (bus.hdg_vld) begin
          frwrd_d = ramp_dn_step(frwrd_q, FRWRD_INC);
          if (frwrd_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    moving_d  = (state_d != IDLE);
    err_vld_d = bus.hdg_vld & (state_q != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frwrd_q   <= '0;
      cnt_q     <= '0;
      target_q  <= '0;
      moving_q  <= 1'b0;
      err_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frwrd_q   <= frwrd_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      moving_q  <= moving_d;
      err_vld_q <= err_vld_d;
      done_q    <= done_d;
    end
  end

  assign bus.cmd_rdy = (state_q == IDLE);
  assign bus.moving  = moving_q;
  assign bus.frwrd   = frwrd_q;
  assign bus.err_vld = err_vld_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer with an arithmetic speed model.
module tb_move_sequencer;
  import move_seq_pkg::*;

  localparam logic [FRWRD_W-1:0] INC = 10'h040;
  localparam logic [FRWRD_W-1:0] MAX = 10'h300;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  move_sequencer_if bus ();

  move_sequencer #(.FRWRD_INC(INC), .FRWRD_MAX(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int mv     = 0;
  int done_cnt = 0;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  // Speed model straight from the ramp rules.
  function automatic int m_up(input int v);
    return (v + int'(INC) > int'(MAX)) ? int'(MAX) : v + int'(INC);
  endfunction

  function automatic int m_dn(input int v);
    return (v < 2 * int'(INC)) ? 0 : v - 2 * int'(INC);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick();
    bus.hdg_vld = 1'b1;
    step();
    bus.hdg_vld = 1'b0;
  endtask

  task automatic issue(input logic [2:0] sqrs);
    bus.cmd_vld  = 1'b1;
    bus.cmd_sqrs = sqrs;
    step();
    bus.cmd_vld  = 1'b0;
    mv = 0;
  endtask

  task automatic pulse_ir();
    bus.cntrIR = 1'b1;
    step();
    bus.cntrIR = 1'b0;
    step();
  endtask

  // Ramp down from the model speed to zero, one tick every 4 cycles.
  task automatic run_ramp_down(input string nm);
    bit fin = 0;
    for (int i = 0; i < 16 && !fin; i++) begin
      mv = m_dn(mv);
      tick();
      n_chk++;
      if (bus.frwrd !== 10'(mv) || bus.err_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_dn%0d: frwrd=%h err_vld=%b, required frwrd=%h err_vld=1", nm, i, bus.frwrd, bus.err_vld, 10'(mv));
      end
      if (mv == 0) begin
        n_chk++;
        if (bus.done !== 1'b1 || bus.moving !== 1'b0 || bus.cmd_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_end: done=%b moving=%b cmd_rdy=%b, required 1 0 1", nm, bus.done, bus.moving, bus.cmd_rdy);
        end
        step();
        n_chk++;
        if (bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done_width: done=%b, required 0", nm, bus.done);
        end
        fin = 1;
      end else begin
        n_chk++;
        if (bus.done !== 1'b0 || bus.moving !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_dn_busy%0d: done=%b moving=%b, required 0 1", nm, i, bus.done, bus.moving);
        end
        gap(3);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_vld = 1'b0; bus.cmd_sqrs = 3'd0; bus.hdg_vld = 1'b0; bus.cntrIR = 1'b1;
    #12;
    n_chk++;
    if (bus.moving !== 1'b0 || bus.frwrd !== 10'h000 || bus.err_vld !== 1'b0 ||
        bus.done !== 1'b0 || bus.cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: moving=%b frwrd=%h err_vld=%b done=%b cmd_rdy=%b, required 0 000 0 0 1",
               bus.moving, bus.frwrd, bus.err_vld, bus.done, bus.cmd_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ramp_up();
    issue(3'd1);
    n_chk++;
    if (bus.moving !== 1'b1 || bus.cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: moving=%b cmd_rdy=%b, required 1 0", bus.moving, bus.cmd_rdy);
    end
    bus.cntrIR = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      mv = m_up(mv);
      tick();
      n_chk++;
      if (bus.frwrd !== 10'(mv) || bus.err_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL up_tick%0d: frwrd=%h err_vld=%b, required frwrd=%h err_vld=1", k, bus.frwrd, bus.err_vld, 10'(mv));
      end
      step();
      n_chk++;
      if (bus.err_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL up_strobe%0d: err_vld=%b, required 0", k, bus.err_vld);
      end
      gap(2);
    end
  endtask

  task automatic test_ramp_down();
    pulse_ir();
    pulse_ir();
    n_chk++;
    if (bus.moving !== 1'b1 || bus.cmd_rdy !== 1'b0 || bus.frwrd !== MAX) begin
      n_fail++;
      $display("FAIL cruise_hit: moving=%b cmd_rdy=%b frwrd=%h, required 1 0 %h", bus.moving, bus.cmd_rdy, bus.frwrd, MAX);
    end
    run_ramp_down("cruise");
  endtask

  task automatic test_early_hit();
    issue(3'd1);
    for (int k = 0; k < 3; k++) begin
      mv = m_up(mv);
      tick();
      gap(3);
    end
    n_chk++;
    if (bus.frwrd !== 10'(mv)) begin
      n_fail++;
      $display("FAIL early_up: frwrd=%h, required %h", bus.frwrd, 10'(mv));
    end
    pulse_ir();
    pulse_ir();
    run_ramp_down("early");
  endtask

  task automatic test_hit_with_hdg();
    issue(3'd1);
    for (int k = 0; k < 4; k++) begin
      mv = m_up(mv);
      tick();
      gap(3);
    end
    pulse_ir();
    bus.cntrIR = 1'b1;
    bus.hdg_vld = 1'b1;
    step();
    bus.cntrIR = 1'b0;
    bus.hdg_vld = 1'b0;
    n_chk++;
    if (bus.frwrd !== 10'(mv) || bus.err_vld !== 1'b1 || bus.moving !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_hdg: frwrd=%h err_vld=%b moving=%b, required %h 1 1", bus.frwrd, bus.err_vld, bus.moving, 10'(mv));
    end
    gap(3);
    run_ramp_down("hit_hdg");
  endtask

  task automatic test_zero_and_ignore();
    int d0;
    issue(3'd0);
    n_chk++;
    if (bus.done !== 1'b1 || bus.moving !== 1'b0 || bus.cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b moving=%b cmd_rdy=%b, required 1 0 1", bus.done, bus.moving, bus.cmd_rdy);
    end
    step();
    n_chk++;
    if (bus.done !== 1'b0 || bus.moving !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: done=%b moving=%b, required 0 0", bus.done, bus.moving);
    end
    d0 = done_cnt;
    issue(3'd1);
    bus.cmd_vld  = 1'b1;
    bus.cmd_sqrs = 3'd5;
    for (int k = 0; k < 2; k++) begin
      mv = m_up(mv);
      tick();
      gap(3);
    end
    pulse_ir();
    pulse_ir();
    bus.cmd_vld = 1'b0;
    run_ramp_down("ignore");
    gap(10);
    n_chk++;
    if (done_cnt - d0 !== 1 || bus.moving !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_done_count: done pulses=%0d moving=%b, required 1 0", done_cnt - d0, bus.moving);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    issue(3'd3);
    for (int k = 0; k < 12; k++) begin
      mv = m_up(mv);
      tick();
      gap(3);
    end
    bus.cntrIR = 1'b1;
    tick();
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.moving !== 1'b0 || bus.frwrd !== 10'h000 || bus.err_vld !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: moving=%b frwrd=%h err_vld=%b done=%b, required 0 000 0 0",
               bus.moving, bus.frwrd, bus.err_vld, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_chk++;
    if (bus.cmd_rdy !== 1'b1 || bus.done !== 1'b0 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL rst_release: cmd_rdy=%b done=%b extra_done=%0d, required 1 0 0", bus.cmd_rdy, bus.done, done_cnt - d0);
    end
    issue(3'd1);
    bus.cntrIR = 1'b0;
    step();
    pulse_ir();
    mv = m_up(mv);
    tick();
    n_chk++;
    if (bus.frwrd !== 10'(mv) || bus.moving !== 1'b1) begin
      n_fail++;
      $display("FAIL held_ir_ignored: frwrd=%h moving=%b, required %h 1", bus.frwrd, bus.moving, 10'(mv));
    end
    gap(3);
    pulse_ir();
    run_ramp_down("post_rst");
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      int sqrs;
      int n_up;
      sqrs = int'($urandom_range(1, 7));
      n_up = int'($urandom_range(0, 14));
      issue(3'(sqrs));
      for (int k = 0; k < n_up; k++) begin
        mv = m_up(mv);
        tick();
        n_chk++;
        if (bus.frwrd !== 10'(mv) || bus.err_vld !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd%0d_up%0d: frwrd=%h err_vld=%b, required %h 1", m, k, bus.frwrd, bus.err_vld, 10'(mv));
        end
        gap(int'($urandom_range(0, 3)));
      end
      for (int p = 0; p < 2 * sqrs; p++) begin
        bit last;
        bit w;
        last = (p == 2 * sqrs - 1);
        w    = last ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!last && $urandom_range(0, 1) == 1) begin
          mv = m_up(mv);
          tick();
        end
        bus.cntrIR  = 1'b1;
        bus.hdg_vld = w;
        step();
        bus.cntrIR  = 1'b0;
        bus.hdg_vld = 1'b0;
        n_chk++;
        if (bus.frwrd !== 10'(mv) || bus.moving !== 1'b1 || bus.err_vld !== w) begin
          n_fail++;
          $display("FAIL rnd%0d_x%0d: frwrd=%h moving=%b err_vld=%b, required %h 1 %b",
                   m, p, bus.frwrd, bus.moving, bus.err_vld, 10'(mv), w);
        end
        step();
      end
      run_ramp_down($sformatf("rnd%0d", m));
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_early_hit();
    test_hit_with_hdg();
    test_zero_and_ignore();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Sequences one straight-line move for the Knight's drive datapath by generating `moving`, `frwrd` and `err_vld` for the PID controller. Accepts a square-count command and ramps `frwrd` up on heading ticks. Counts centre-IR line crossings, then ramps `frwrd` back down to zero and reports completion. Sits between the command processor and the PID block.

## Interface
Parameters:
- `FRWRD_INC`, 10'h004: ramp-up step per heading tick; ramp-down step is 2×`FRWRD_INC`.
- `FRWRD_MAX`, 10'h300: cruise speed; ramp-up saturates here.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cmd_vld`, in, 1: move command valid.
- `cmd_sqrs`, in, 3: squares to move, 0–7.
- `cmd_rdy`, out, 1: block can accept a command.
- `hdg_vld`, in, 1: single-cycle heading-sample tick from the gyro path.
- `cntrIR`, in, 1: centre IR sensor, already synchronized, high over a line.
- `moving`, out, 1: drive active; PID enable.
- `frwrd`, out, 10: forward speed to PID.
- `err_vld`, out, 1: PID error-accumulate strobe.
- `done`, out, 1: single-cycle pulse when a move completes.

## Operation
- States: `IDLE`, `RAMP_UP`, `CRUISE`, `RAMP_DN`.
- `cmd_rdy` = (state==`IDLE`), combinational.
- Command accepted when `cmd_vld & cmd_rdy`. On accept, latch `target` = 2×`cmd_sqrs` (4 bits) and clear the crossing counter.
  - Accept with `cmd_sqrs`≠0 → `RAMP_UP`.
  - Accept with `cmd_sqrs`==0 → stay in `IDLE`, pulse `done` next cycle, `moving` stays low.
- `cmd_vld` while not ready is ignored; no queuing.
- Crossing detect:
  - Rising edge of `cntrIR` via one history flop; the history flop resets to 1, so a line under the sensor at reset is not counted.
  - Edges increment the 4-bit counter only in `RAMP_UP`/`CRUISE`; they are ignored in `IDLE`/`RAMP_DN`.
- `RAMP_UP`:
  - On `hdg_vld`, `frwrd` ← min(`frwrd`+`FRWRD_INC`, `FRWRD_MAX`). Compute in 11 bits; no wrap.
  - Reaching `FRWRD_MAX` → `CRUISE`.
- `CRUISE`: `frwrd` holds.
- Target reached (counter+edge == `target`) in `RAMP_UP` or `CRUISE` → `RAMP_DN`.
  - This has priority over the `RAMP_UP`→`CRUISE` transition.
  - `frwrd` is not updated in that cycle, even if `hdg_vld` is high.
- `RAMP_DN`:
  - On `hdg_vld`, `frwrd` ← (`frwrd` < 2×`FRWRD_INC`) ? 0 : `frwrd` − 2×`FRWRD_INC`.
  - When the update yields 0 → `IDLE`, with `done` high and `moving` low from that same edge.
- `moving` registered: 1 in all states except `IDLE`.
- `err_vld` registered: `hdg_vld & (state≠IDLE)`.

## Timing
- Reset values: `moving`=0, `frwrd`=0, `err_vld`=0, `done`=0, state=`IDLE` (so `cmd_rdy`=1), counter=0, target=0, IR history=1.
- Command accepted at edge N → `moving`=1 after edge N; the first possible `frwrd` step comes from an `hdg_vld` sampled at edge N+1 or later.
- `hdg_vld` sampled at edge K → `frwrd` step and `err_vld` both visible after edge K. This is one-cycle latency, aligned so the PID sees the new speed with its strobe.
- `cntrIR` rise seen at edge K → counter updated after K; a target hit at K puts the state in `RAMP_DN` after K.
- `done` is exactly one cycle wide. A new command is accepted no earlier than the cycle in which `done` is high.
- Async reset mid-move: all outputs clear immediately; the in-flight move is dropped with no `done`.

## Structure
- Package `move_seq_pkg`:
  - `move_state_t` enum (`IDLE`, `RAMP_UP`, `CRUISE`, `RAMP_DN`).
  - Default `FRWRD_INC`/`FRWRD_MAX` localparams.
  - `FRWRD_W`=10.
- One natural sub-module, `rise_det`: history flop plus edge pulse, with reset value as a parameter. All other logic is inline: state register, ramp arithmetic with saturation, counter.

## Test plan
For tests 1–4, use `FRWRD_INC`=10'h040, `FRWRD_MAX`=10'h300, and `hdg_vld` every 4 cycles.

1. Reset with `cntrIR`=1, then `cmd_sqrs`=1 → `cmd_rdy` falls, `moving`=1. `frwrd` steps 0x040…0x300 over 12 ticks, each with `err_vld`; state `CRUISE`.
2. Continue: two `cntrIR` pulses → `RAMP_DN`. `frwrd` 0x280, 0x200, …, 0 over 6 ticks. `done` is one cycle, `moving`=0 on the same edge, `cmd_rdy`=1.
3. `cmd_sqrs`=1 with two `cntrIR` pulses arriving after 3 ticks (`frwrd`=0x0C0) → immediate `RAMP_DN`. Ramp-down saturates 0x0C0→0x040→0 over 2 ticks, then `done`.
4. Target crossing coincident with `hdg_vld` during `RAMP_UP` → `frwrd` unchanged that cycle; next tick decrements by 0x080.
5. `cmd_sqrs`=0 → `done` pulse next cycle, `moving` never asserts. `cmd_vld` pulses during a move are ignored, and no second `done` occurs.
6. `rst_n` asserted mid-`CRUISE` → `moving`/`frwrd`/`err_vld` are 0 asynchronously, no `done`. After release, `cmd_rdy`=1 and an already-high `cntrIR` is not counted.
